// File: rtl/cpu_pkg.sv
// Types and defaults shared by the memory arbiter and the datapath.
package cpu_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        ACK    = 3'd3,
        HALTED = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    function automatic logic is_busy(arb_state_t s);
        return (s == ISSUE) || (s == WAIT) || (s == ACK);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals around the unified-memory arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              halt_req;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              busy;
    logic              halted;
    logic              err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, halt_req,
               mem_rdata, mem_valid,
        output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr,
               mem_wdata, busy, halted, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, halt_req,
               mem_rdata, mem_valid,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr,
               mem_wdata, busy, halted, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported memory between fetch and data, with timeout and halt.
//   state  | meaning
//   IDLE   | arbitrate requests, or enter HALTED when halt_req is high
//   ISSUE  | mem_en strobe for the latched owner
//   WAIT   | wait for mem_valid, abort after TIMEOUT+1 cycles
//   ACK    | one-cycle ack to the owner
//   HALTED | memory quiesced, left only through reset
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_D   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int                DCNT_W   = $clog2(MAX_D + 1);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(MAX_D);
    localparam logic [7:0]        TCNT_MAX = 8'(TIMEOUT);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              grant_d;

    // Data wins unless fetch has already watched MAX_D data grants go by.
    assign grant_d = bus.d_req && !(bus.if_req && (dcnt_q == DCNT_MAX));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        dcnt_d      = dcnt_q;
        tcnt_d      = tcnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (bus.halt_req) begin
                    state_d = HALTED;
                end else if (bus.if_req || bus.d_req) begin
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    if (grant_d) begin
                        owner_d     = OWN_D;
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        if (!bus.if_req)
                            dcnt_d = '0;
                        else if (dcnt_q != DCNT_MAX)
                            dcnt_d = dcnt_q + 1'b1;
                    end else begin
                        owner_d     = OWN_IF;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        dcnt_d      = '0;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                tcnt_d  = '0;
            end
            WAIT: begin
                if (bus.mem_valid || (tcnt_q == TCNT_MAX)) begin
                    state_d = ACK;
                    tcnt_d  = '0;
                    if (owner_q == OWN_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = bus.mem_valid ? bus.mem_rdata : '0;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_valid ? bus.mem_rdata : '0;
                    end
                    if (!bus.mem_valid)
                        err_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            ACK:     state_d = IDLE;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase

        busy_d   = is_busy(state_d);
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            dcnt_q      <= '0;
            tcnt_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            dcnt_q      <= dcnt_d;
            tcnt_q      <= tcnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-transaction vector table plus fairness, timeout, halt and reset sequences.
module tb_mem_arbiter;

    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(
        .ADDR_W (16),
        .DATA_W (16),
        .MAX_D  (4),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        if_req;
        logic        d_req;
        logic        d_we;
        logic [15:0] if_addr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic [15:0] rdata;
        logic        exp_d;
        logic        exp_we;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_mem_en(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.mem_en && n < 20);
        chk("mem_en_seen", 32'(bus.mem_en), 1);
    endtask

    task automatic apply_vec(input vec_t v);
        int n;
        bus.if_req  = v.if_req;
        bus.if_addr = v.if_addr;
        bus.d_req   = v.d_req;
        bus.d_we    = v.d_we;
        bus.d_addr  = v.d_addr;
        bus.d_wdata = v.d_wdata;
        wait_mem_en(n);
        chk("issue_latency", 32'(n), 1);
        chk("issue_we", 32'(bus.mem_we), 32'(v.exp_we));
        chk("issue_addr", 32'(bus.mem_addr), 32'(v.exp_addr));
        if (v.exp_we) chk("issue_wdata", 32'(bus.mem_wdata), 32'(v.d_wdata));
        chk("issue_busy", 32'(bus.busy), 1);
        tick();
        chk("wait_mem_en_low", 32'(bus.mem_en), 0);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = v.rdata;
        tick();
        bus.mem_valid = 1'b0;
        chk("ack_d", 32'(bus.d_ack), 32'(v.exp_d));
        chk("ack_if", 32'(bus.if_ack), 32'(!v.exp_d));
        if (!v.exp_we) begin
            if (v.exp_d) chk("d_rdata", 32'(bus.d_rdata), 32'(v.rdata));
            else         chk("if_rdata", 32'(bus.if_rdata), 32'(v.rdata));
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();
        chk("ack_pulse_d", 32'(bus.d_ack), 0);
        chk("ack_pulse_if", 32'(bus.if_ack), 0);
        chk("idle_busy", 32'(bus.busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_ack"}, 32'(bus.if_ack), 0);
        chk({tag, "_d_ack"}, 32'(bus.d_ack), 0);
        chk({tag, "_mem_en"}, 32'(bus.mem_en), 0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
        chk({tag, "_if_rdata"}, 32'(bus.if_rdata), 0);
        chk({tag, "_d_rdata"}, 32'(bus.d_rdata), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_halted"}, 32'(bus.halted), 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   acks;
        int   ens;
        logic exp_d;

        //          ifr  dr   we   if_addr   d_addr    wdata     rdata     exp_d exp_we exp_addr
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'hA5A5, 1'b0, 1'b0, 16'h0010};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0200, 16'h1234, 16'h0000, 1'b1, 1'b1, 16'h0200};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0300, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 16'h0300};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'h0400, 16'h0000, 16'h1111, 1'b1, 1'b0, 16'h0400};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0000, 16'h2222, 1'b0, 1'b0, 16'h0030};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 16'h0040, 16'h0500, 16'h5555, 16'h5A5A, 1'b1, 1'b1, 16'h0500};

        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.halt_req  = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_valid = 1'b0;

        tick();
        tick();
        rst_n = 1'b1;
        chk_all_zero("reset");

        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // Timeout on a load with no response.
        chk("err_before_timeout", 32'(bus.err), 0);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h0600;
        wait_mem_en(n);
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.d_ack && n < 400);
        chk("timeout_ack_cycles", 32'(n), TIMEOUT + 1);
        chk("timeout_d_ack", 32'(bus.d_ack), 1);
        chk("timeout_d_rdata", 32'(bus.d_rdata), 0);
        chk("timeout_err", 32'(bus.err), 1);
        bus.d_req = 1'b0;
        tick();
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 16'hFFFF;
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            acks += int'(bus.if_ack) + int'(bus.d_ack);
        end
        bus.mem_valid = 1'b0;
        chk("late_valid_acks", 32'(acks), 0);
        chk("late_valid_d_rdata", 32'(bus.d_rdata), 0);
        chk("late_valid_busy", 32'(bus.busy), 0);
        apply_vec('{1'b1, 1'b0, 1'b0, 16'h0050, 16'h0000, 16'h0000, 16'h3333, 1'b0, 1'b0, 16'h0050});
        chk("err_sticky", 32'(bus.err), 1);

        // Fairness with both requesters held high continuously.
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h00A0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 16'h0A00;
        for (int t = 0; t < 10; t++) begin
            exp_d = ((t % 5) != 4);
            wait_mem_en(n);
            chk("fair_spacing", 32'(n), (t == 0) ? 1 : 2);
            chk("fair_owner_addr", 32'(bus.mem_addr), exp_d ? 32'h0A00 : 32'h00A0);
            tick();
            bus.mem_valid = 1'b1;
            bus.mem_rdata = 16'(t + 16'h0100);
            tick();
            bus.mem_valid = 1'b0;
            chk("fair_d_ack", 32'(bus.d_ack), 32'(exp_d));
            chk("fair_if_ack", 32'(bus.if_ack), 32'(!exp_d));
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();

        // Halt raised while a fetch is waiting on memory.
        do_reset();
        chk("reset_clears_err", 32'(bus.err), 0);
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0060;
        wait_mem_en(n);
        tick();
        bus.halt_req = 1'b1;
        tick();
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 16'h7777;
        tick();
        bus.mem_valid = 1'b0;
        chk("halt_if_ack", 32'(bus.if_ack), 1);
        chk("halt_if_rdata", 32'(bus.if_rdata), 16'h7777);
        chk("halt_not_yet_ack", 32'(bus.halted), 0);
        bus.if_req = 1'b0;
        tick();
        chk("halt_not_yet_idle", 32'(bus.halted), 0);
        chk("halt_idle_busy", 32'(bus.busy), 0);
        tick();
        chk("halted", 32'(bus.halted), 1);
        bus.if_req   = 1'b1;
        bus.d_req    = 1'b1;
        bus.halt_req = 1'b0;
        ens = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            ens += int'(bus.mem_en);
        end
        chk("halted_no_mem_en", 32'(ens), 0);
        chk("halted_stays", 32'(bus.halted), 1);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;

        // Reset in the middle of a store's WAIT phase.
        do_reset();
        apply_vec('{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0800, 16'h0000, 16'h9999, 1'b1, 1'b0, 16'h0800});
        apply_vec('{1'b1, 1'b0, 1'b0, 16'h0900, 16'h0000, 16'h0000, 16'h8888, 1'b0, 1'b0, 16'h0900});
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0700;
        bus.d_wdata = 16'hCAFE;
        wait_mem_en(n);
        tick();
        chk("pre_reset_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.d_req = 1'b0;
        chk_all_zero("midreset");
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            acks += int'(bus.if_ack) + int'(bus.d_ack);
        end
        bus.mem_valid = 1'b0;
        chk("stray_valid_acks", 32'(acks), 0);
        chk("stray_valid_d_rdata", 32'(bus.d_rdata), 0);
        chk("stray_valid_busy", 32'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the processor's single-ported unified memory between the instruction-fetch path and the data path (LW/SW). Data accesses have priority, with a bounded-starvation guarantee for fetch. The block owns the memory handshake and times out hung transactions. It also implements the halt sequence: after HLT is decoded, the in-flight access completes and then memory is quiesced.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MAX_D, 4, consecutive data grants allowed while a fetch is pending
- TIMEOUT, 255, maximum cycles in WAIT before abort (8-bit counter)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request (level, held until if_ack)
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_rdata  out  DATA_W  fetched word, valid with if_ack
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request (level, held until d_ack)
- d_we  in  1  1 = SW, 0 = LW
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_ack
- d_ack  out  1  one-cycle data completion pulse
- halt_req  in  1  HLT decoded (level)
- mem_en  out  1  one-cycle memory command strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_valid
- mem_valid  in  1  memory response strobe (read data or write done)
- busy  out  1  state != IDLE and state != HALTED
- halted  out  1  state == HALTED
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, ISSUE, WAIT, ACK, HALTED.
- IDLE:
  - if halt_req -> HALTED; halt wins over any pending request.
  - else if either req is high, latch owner, addr, we and wdata -> ISSUE.
  - else stay in IDLE.
- Arbitration in IDLE:
  - d_req only -> data; if_req only -> fetch.
  - both pending: data, unless dcnt == MAX_D, in which case fetch.
  - dcnt increments on each data grant made while if_req is high; clears on a fetch grant or on a data grant with if_req low; saturates at MAX_D.
- ISSUE: mem_en = 1 for exactly this cycle, with mem_we/mem_addr/mem_wdata from the latch; mem_we = 0 for fetch. -> WAIT.
- WAIT:
  - mem_valid -> capture mem_rdata into the owner's rdata register -> ACK.
  - tcnt counts cycles in WAIT. When tcnt == TIMEOUT with no mem_valid: err <= 1, rdata <= 0 -> ACK.
  - a late mem_valid from the aborted access is ignored.
- ACK: the owner's ack = 1 for this cycle only; its rdata is held until the next ack for that port. -> IDLE.
- HALTED: no grants; mem_en = 0; only rst_n exits.
- mem_valid outside WAIT is ignored.
- Write path: d_rdata on an SW ack is don't-care; the bench checks only the ack.

## Timing
- Reset (rst_n = 0 at an edge), all outputs and internal state:
  - state = IDLE; acks = 0; mem_en = 0; mem_we = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
  - err = 0; halted = 0; busy = 0; dcnt = 0; tcnt = 0.
- Reset mid-transaction: the access is abandoned, no ack is issued, and any following mem_valid is ignored.
- Cycle timing for a request first sampled high in IDLE at cycle N:
  - mem_en at N+1.
  - earliest mem_valid at N+2.
  - ack at N+3.
  - IDLE again at N+4.
  - Minimum latency is 3 cycles; throughput is 1 access per 4 cycles at zero memory wait.
- Requester rules:
  - keep req, addr and data stable until its ack.
  - req sampled high at N+4 is a new request, so back-to-back requests are legal.
- halt_req raised while busy: the current access completes normally (ack issued). Transition is ACK -> IDLE -> HALTED; halted goes high 1 cycle after IDLE.
- Simultaneous if_req and d_req are resolved only in IDLE. A request arriving during ISSUE/WAIT/ACK waits.

## Structure
- Shared package cpu_pkg holds:
  - the state enum (arb_state_t: IDLE, ISSUE, WAIT, ACK, HALTED).
  - the owner encoding (OWN_IF = 0, OWN_D = 1).
  - ADDR_W/DATA_W defaults shared with the datapath.
- Single flat module. Counters (dcnt, tcnt) are inline; no sub-module is warranted.

## Test plan
- Single fetch: if_req = 1, if_addr = 0x0010, mem_valid 1 cycle after mem_en with mem_rdata = 0xA5A5 -> mem_en at N+1 with mem_we = 0, if_ack at N+3 with if_rdata = 0xA5A5, d_ack never asserted.
- Store: d_req = 1, d_we = 1, d_addr = 0x0200, d_wdata = 0x1234 -> mem_en = 1, mem_we = 1, mem_addr = 0x0200, mem_wdata = 0x1234 in the same cycle; d_ack 2 cycles later.
- Fairness: if_req and d_req held high continuously, zero-wait memory -> 4 data grants, then 1 fetch, repeating; fetch is never delayed more than 4 transactions.
- Timeout: d_req LW with mem_valid never asserted -> d_ack exactly TIMEOUT+1 cycles after entering WAIT, d_rdata = 0, err = 1 and sticky. A later mem_valid is ignored.
- Halt: halt_req raised during WAIT of a fetch -> if_ack still issued; halted = 1 two cycles after ack; further requests produce no mem_en.
- Reset mid-WAIT: rst_n low for 1 cycle during WAIT -> no ack, all outputs 0, and a stray mem_valid afterwards produces no ack.
